// File: rtl/pw_change_if.sv
// ============================================================================
// pw_change_if : user-entry and display bundle of the password-change block
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface pw_change_if;
    logic        chg_req;
    logic        auth;
    logic [3:0]  USERIN;
    logic [3:0]  KEY;
    logic [15:0] pw_out;
    logic        pw_upd;
    logic        busy;
    logic        LEDG;
    logic        LEDR;
    logic [6:0]  H0;
    logic [6:0]  H1;
    logic [6:0]  H2;
    logic [6:0]  H3;

    modport master (
        output chg_req, auth, USERIN, KEY,
        input  pw_out, pw_upd, busy, LEDG, LEDR, H0, H1, H2, H3
    );

    modport slave (
        input  chg_req, auth, USERIN, KEY,
        output pw_out, pw_upd, busy, LEDG, LEDR, H0, H1, H2, H3
    );
endinterface

`default_nettype wire

// File: rtl/pw_change_ctrl.sv
// ============================================================================
// pw_change_ctrl : two-pass (entry + confirm) 4-digit password programming
// Optional entry inactivity timeout: define PW_CHG_TIMEOUT_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module pw_change_ctrl #(
    parameter logic [15:0] DEFAULT_PW     = 16'h01AF,
    parameter int          HOLD_CYCLES    = 7,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  wire logic  clk_1,
    input  wire logic  rst,
    pw_change_if.slave bus
);

    localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef PW_CHG_TIMEOUT_EN
    localparam logic [CNT_W-1:0] C_TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    localparam logic [6:0] C_DASH  = 7'b0111111;
    localparam logic [6:0] C_BLANK = 7'b1111111;
    localparam logic [6:0] C_GL_D  = 7'b0100001;
    localparam logic [6:0] C_GL_O  = 7'b0100011;
    localparam logic [6:0] C_GL_N  = 7'b0101011;
    localparam logic [6:0] C_GL_E  = 7'b0000110;
    localparam logic [6:0] C_GL_R  = 7'b0101111;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_NEW0  = 4'd1,
        S_NEW1  = 4'd2,
        S_NEW2  = 4'd3,
        S_NEW3  = 4'd4,
        S_CONF0 = 4'd5,
        S_CONF1 = 4'd6,
        S_CONF2 = 4'd7,
        S_CONF3 = 4'd8,
        S_CHECK = 4'd9,
        S_DONE  = 4'd10,
        S_ERR   = 4'd11
    } state_t;

    state_t           r_state;
    logic [15:0]      r_pw;
    logic [15:0]      r_newpw;
    logic [15:0]      r_confpw;
    logic             r_pw_upd;
    logic             r_busy;
    logic             r_ledg;
    logic             r_ledr;
    logic             r_blink;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_h [4];

    logic             w_entry;
    logic             w_conf;
    logic [1:0]       w_idx;
    state_t           w_next;
    logic             w_key_hit;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Which digit slot the current entry state owns, and where a confirm leads.
    always_comb begin
        w_entry = 1'b1;
        w_conf  = 1'b0;
        w_idx   = 2'd0;
        w_next  = S_IDLE;
        case (r_state)
            S_NEW0:  begin w_idx = 2'd0; w_next = S_NEW1;  end
            S_NEW1:  begin w_idx = 2'd1; w_next = S_NEW2;  end
            S_NEW2:  begin w_idx = 2'd2; w_next = S_NEW3;  end
            S_NEW3:  begin w_idx = 2'd3; w_next = S_CONF0; end
            S_CONF0: begin w_idx = 2'd0; w_conf = 1'b1; w_next = S_CONF1; end
            S_CONF1: begin w_idx = 2'd1; w_conf = 1'b1; w_next = S_CONF2; end
            S_CONF2: begin w_idx = 2'd2; w_conf = 1'b1; w_next = S_CONF3; end
            S_CONF3: begin w_idx = 2'd3; w_conf = 1'b1; w_next = S_CHECK; end
            default: w_entry = 1'b0;
        endcase
        w_key_hit = ~bus.KEY[2'd3 - w_idx];
    end

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pw     <= DEFAULT_PW;
            r_newpw  <= 16'h0000;
            r_confpw <= 16'h0000;
            r_pw_upd <= 1'b0;
            r_busy   <= 1'b0;
            r_ledg   <= 1'b0;
            r_ledr   <= 1'b0;
            r_blink  <= 1'b0;
            r_cnt    <= '0;
            for (int k = 0; k < 4; k++) r_h[k] <= C_DASH;
        end else begin
            r_pw_upd <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ledg <= 1'b0;
                    r_ledr <= 1'b0;
                    for (int k = 0; k < 4; k++) r_h[k] <= C_DASH;
                    if (bus.chg_req && bus.auth) begin
                        r_state  <= S_NEW0;
                        r_busy   <= 1'b1;
                        r_blink  <= 1'b0;
                        r_newpw  <= 16'h0000;
                        r_confpw <= 16'h0000;
                        r_cnt    <= '0;
                    end
                end
                S_CHECK: begin
                    r_cnt <= '0;
                    if (r_newpw == r_confpw) begin
                        r_state  <= S_DONE;
                        r_pw     <= r_newpw;
                        r_pw_upd <= 1'b1;
                        r_ledg   <= 1'b1;
                        r_h[0]   <= C_GL_D;
                        r_h[1]   <= C_GL_O;
                        r_h[2]   <= C_GL_N;
                        r_h[3]   <= C_GL_E;
                    end else begin
                        r_state <= S_ERR;
                        r_ledr  <= 1'b1;
                        r_h[0]  <= C_GL_E;
                        r_h[1]  <= C_GL_R;
                        r_h[2]  <= C_GL_R;
                        r_h[3]  <= C_DASH;
                    end
                end
                S_DONE, S_ERR: begin
                    if (r_cnt == C_HOLD_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_ledg  <= 1'b0;
                        r_ledr  <= 1'b0;
                        for (int k = 0; k < 4; k++) r_h[k] <= C_DASH;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // Dropping chg_req beats a key press; stray encodings also land here.
                    if (!w_entry || !bus.chg_req) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_blink <= 1'b0;
                        r_cnt   <= '0;
                        for (int k = 0; k < 4; k++) r_h[k] <= C_DASH;
                    end else if (w_key_hit) begin
                        if (w_conf) r_confpw[4'd15 - {w_idx, 2'b00} -: 4] <= bus.USERIN;
                        else        r_newpw [4'd15 - {w_idx, 2'b00} -: 4] <= bus.USERIN;
                        r_h[w_idx] <= hex7(bus.USERIN);
                        r_blink    <= ~r_blink;
                        r_state    <= w_next;
                        r_cnt      <= '0;
                        if (r_state == S_NEW3) begin
                            for (int k = 0; k < 4; k++) r_h[k] <= C_DASH;
                        end
                    end
`ifdef PW_CHG_TIMEOUT_EN
                    else if (r_cnt == C_TO_LAST) begin
                        r_state <= S_ERR;
                        r_cnt   <= '0;
                        r_ledr  <= 1'b1;
                        r_h[0]  <= C_GL_E;
                        r_h[1]  <= C_GL_R;
                        r_h[2]  <= C_GL_R;
                        r_h[3]  <= C_DASH;
                    end
`endif
                    else begin
                        r_h[w_idx] <= r_blink ? C_BLANK : hex7(bus.USERIN);
                        r_blink    <= ~r_blink;
`ifdef PW_CHG_TIMEOUT_EN
                        r_cnt      <= r_cnt + CNT_W'(1);
`endif
                    end
                end
            endcase
        end
    end

    assign bus.pw_out = r_pw;
    assign bus.pw_upd = r_pw_upd;
    assign bus.busy   = r_busy;
    assign bus.LEDG   = r_ledg;
    assign bus.LEDR   = r_ledr;
    assign bus.H0     = r_h[0];
    assign bus.H1     = r_h[1];
    assign bus.H2     = r_h[2];
    assign bus.H3     = r_h[3];

endmodule

`default_nettype wire

// File: tb/tb_pw_change_ctrl.sv
// ============================================================================
// tb_pw_change_ctrl : scoreboard bench for pw_change_ctrl
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pw_change_ctrl;

    localparam logic [6:0] C_DASH = 7'b0111111;
    localparam logic [27:0] C_ALL_DASH = {4{C_DASH}};
    localparam logic [27:0] C_DONE_H   = {7'b0100001, 7'b0100011, 7'b0101011, 7'b0000110};
    localparam logic [27:0] C_ERR_H    = {7'b0000110, 7'b0101111, 7'b0101111, 7'b0111111};

    logic clk_1 = 1'b0;
    logic rst;

    pw_change_if bus ();

    pw_change_ctrl #(
        .DEFAULT_PW    (16'h01AF),
        .HOLD_CYCLES   (7),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_1(clk_1),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk_1 = ~clk_1;

    typedef struct {
        bit          ok;
        logic [15:0] pw;
    } exp_t;

    exp_t sb[$];
    int   n_cmp     = 0;
    int   n_err     = 0;
    int   upd_count = 0;

    always @(posedge clk_1) if (bus.pw_upd === 1'b1) upd_count++;

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[d];
    endfunction

    task automatic step();
        @(posedge clk_1);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.chg_req = 1'b0;
        bus.auth    = 1'b0;
        bus.KEY     = 4'hF;
        bus.USERIN  = 4'h0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic press(input logic [3:0] val, input int pos);
        logic [3:0] k;
        k          = 4'b1000 >> pos;
        bus.USERIN = val;
        bus.KEY    = ~k;
        step();
        bus.KEY    = 4'hF;
        step();
    endtask

    task automatic start_change();
        bus.chg_req = 1'b1;
        bus.auth    = 1'b1;
        step();
    endtask

    task automatic run_change(input logic [15:0] npw, input logic [15:0] cpw);
        start_change();
        for (int k = 0; k < 4; k++) press(npw[15 - 4*k -: 4], k);
        for (int k = 0; k < 4; k++) press(cpw[15 - 4*k -: 4], k);
        bus.chg_req = 1'b0;
        bus.auth    = 1'b0;
    endtask

    // Consume one expected result once the DUT shows DONE or ERR.
    task automatic wait_result();
        exp_t e;
        bit   seen = 1'b0;
        int   hold = 0;
        int   upd0;
        logic [27:0] exp_h;
        upd0 = upd_count;
        for (int i = 0; i < 40; i++) begin
            if (bus.LEDG === 1'b1 || bus.LEDR === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_empty: result seen=%0d with no expectation queued", seen);
            return;
        end
        e = sb.pop_front();
        if (!seen) begin
            n_err++;
            $display("FAIL result_timeout: no DONE/ERR within 40 cycles, want ok=%0d", e.ok);
            return;
        end
        exp_h = e.ok ? C_DONE_H : C_ERR_H;
        n_cmp++;
        if ({bus.LEDG, bus.LEDR} !== {e.ok, ~e.ok}) begin
            n_err++;
            $display("FAIL result_leds: got LEDG/LEDR=%b%b want %b%b", bus.LEDG, bus.LEDR, e.ok, ~e.ok);
        end
        n_cmp++;
        if (bus.pw_out !== e.pw) begin
            n_err++;
            $display("FAIL result_pw: got %h want %h", bus.pw_out, e.pw);
        end
        n_cmp++;
        if ({bus.H0, bus.H1, bus.H2, bus.H3} !== exp_h) begin
            n_err++;
            $display("FAIL result_disp: got %h want %h", {bus.H0, bus.H1, bus.H2, bus.H3}, exp_h);
        end
        n_cmp++;
        if (bus.pw_upd !== e.ok || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL result_upd_busy: got upd=%b busy=%b want upd=%b busy=1", bus.pw_upd, bus.busy, e.ok);
        end
        while ((bus.LEDG === 1'b1 || bus.LEDR === 1'b1) && hold < 30) begin
            hold++;
            step();
        end
        n_cmp++;
        if (hold != 7) begin
            n_err++;
            $display("FAIL result_hold: got %0d cycles want 7", hold);
        end
        n_cmp++;
        if (bus.busy !== 1'b0 || {bus.H0, bus.H1, bus.H2, bus.H3} !== C_ALL_DASH) begin
            n_err++;
            $display("FAIL back_to_idle: got busy=%b H=%h want busy=0 H=%h", bus.busy,
                     {bus.H0, bus.H1, bus.H2, bus.H3}, C_ALL_DASH);
        end
        n_cmp++;
        if (upd_count - upd0 != (e.ok ? 1 : 0)) begin
            n_err++;
            $display("FAIL upd_pulses: got %0d want %0d", upd_count - upd0, e.ok ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_cmp++;
        if (bus.pw_out !== 16'h01AF || bus.pw_upd !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_regs: got pw=%h upd=%b busy=%b want 01af 0 0", bus.pw_out, bus.pw_upd, bus.busy);
        end
        n_cmp++;
        if ({bus.H0, bus.H1, bus.H2, bus.H3} !== C_ALL_DASH || {bus.LEDG, bus.LEDR} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_disp: got H=%h leds=%b%b want H=%h leds=00",
                     {bus.H0, bus.H1, bus.H2, bus.H3}, bus.LEDG, bus.LEDR, C_ALL_DASH);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_commit();
        start_change();
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL entry_busy: got %b want 1", bus.busy);
        end
        press(4'h1, 0);
        n_cmp++;
        if (bus.H0 !== seg(4'h1)) begin
            n_err++;
            $display("FAIL entry_digit0_disp: got %b want %b", bus.H0, seg(4'h1));
        end
        press(4'h2, 1);
        press(4'h3, 2);
        press(4'h4, 3);
        n_cmp++;
        if ({bus.H1, bus.H2, bus.H3} !== {3{C_DASH}}) begin
            n_err++;
            $display("FAIL conf_dashes: got %h want %h", {bus.H1, bus.H2, bus.H3}, {3{C_DASH}});
        end
        sb.push_back('{ok: 1'b1, pw: 16'h1234});
        for (int k = 0; k < 4; k++) press(4'(k + 1), k);
        bus.chg_req = 1'b0;
        bus.auth    = 1'b0;
        wait_result();
    endtask

    task automatic test_mismatch();
        do_reset();
        sb.push_back('{ok: 1'b0, pw: 16'h01AF});
        run_change(16'h1234, 16'h1235);
        wait_result();
    endtask

    task automatic test_no_auth();
        int upd0;
        upd0 = upd_count;
        bus.chg_req = 1'b1;
        bus.auth    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if (bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL no_auth_idle: cycle %0d got busy=%b want 0", i, bus.busy);
            end
        end
        bus.auth = 1'b1;
        step();
        press(4'h9, 0);
        press(4'h8, 1);
        bus.USERIN  = 4'h7;
        bus.KEY     = 4'b1101;
        bus.chg_req = 1'b0;
        step();
        bus.KEY  = 4'hF;
        bus.auth = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || {bus.H0, bus.H1, bus.H2, bus.H3} !== C_ALL_DASH) begin
            n_err++;
            $display("FAIL cancel_idle: got busy=%b H=%h want 0 %h", bus.busy,
                     {bus.H0, bus.H1, bus.H2, bus.H3}, C_ALL_DASH);
        end
        repeat (3) step();
        n_cmp++;
        if (bus.pw_out !== 16'h01AF || upd_count != upd0 || bus.LEDG !== 1'b0 || bus.LEDR !== 1'b0) begin
            n_err++;
            $display("FAIL cancel_nocommit: got pw=%h upd=%0d leds=%b%b want 01af 0 00",
                     bus.pw_out, upd_count - upd0, bus.LEDG, bus.LEDR);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sb.push_back('{ok: 1'b1, pw: 16'h1234});
        run_change(16'h1234, 16'h1234);
        wait_result();
        start_change();
        press(4'h5, 0);
        press(4'h6, 1);
        press(4'h7, 2);
        press(4'h8, 3);
        press(4'h5, 0);
        press(4'h6, 1);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.pw_out !== 16'h1234) begin
            n_err++;
            $display("FAIL mid_conf2: got busy=%b pw=%h want 1 1234", bus.busy, bus.pw_out);
        end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.pw_out !== 16'h01AF || bus.busy !== 1'b0 || bus.pw_upd !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_regs: got pw=%h busy=%b upd=%b want 01af 0 0",
                     bus.pw_out, bus.busy, bus.pw_upd);
        end
        n_cmp++;
        if ({bus.H0, bus.H1, bus.H2, bus.H3} !== C_ALL_DASH || {bus.LEDG, bus.LEDR} !== 2'b00) begin
            n_err++;
            $display("FAIL async_reset_disp: got H=%h leds=%b%b want %h 00",
                     {bus.H0, bus.H1, bus.H2, bus.H3}, bus.LEDG, bus.LEDR, C_ALL_DASH);
        end
        bus.chg_req = 1'b0;
        bus.auth    = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        start_change();
        press(4'h0, 0);
`ifdef PW_CHG_TIMEOUT_EN
        sb.push_back('{ok: 1'b0, pw: 16'h01AF});
        wait_result();
        bus.chg_req = 1'b0;
        bus.auth    = 1'b0;
        step();
`else
        repeat (20) step();
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.LEDR !== 1'b0 || bus.LEDG !== 1'b0) begin
            n_err++;
            $display("FAIL no_timeout_wait: got busy=%b leds=%b%b want 1 00", bus.busy, bus.LEDG, bus.LEDR);
        end
        n_cmp++;
        if (bus.H0 !== seg(4'h0)) begin
            n_err++;
            $display("FAIL no_timeout_digit0: got %b want %b", bus.H0, seg(4'h0));
        end
        bus.chg_req = 1'b0;
        bus.auth    = 1'b0;
        step();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.pw_out !== 16'h01AF) begin
            n_err++;
            $display("FAIL no_timeout_cancel: got busy=%b pw=%h want 0 01af", bus.busy, bus.pw_out);
        end
`endif
    endtask

    initial begin
        rst         = 1'b1;
        bus.chg_req = 1'b0;
        bus.auth    = 1'b0;
        bus.KEY     = 4'hF;
        bus.USERIN  = 4'h0;
        test_reset();
        test_commit();
        test_mismatch();
        test_no_auth();
        test_reset_mid();
        test_timeout();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pw_change_ctrl.md
Name: pw_change_ctrl

Overview:
Password programming side of the lock: lets an authorised user enter a new 4-digit hex password twice (entry + confirm) on the same switches/keys/7-seg displays, and commits it to the stored-password register that the lock's verifier compares against. Runs on the slow divided clock clk_1. Drives pw_out, which replaces the lock's hard-wired password. Displays and LEDs use the lock's active-low encoding: bit6=g … bit0=a.

Parameters:
DEFAULT_PW, 16'h01AF, password loaded into pw_out on reset
HOLD_CYCLES, 7, clk_1 cycles the DONE/ERR result is shown before returning to IDLE
TIMEOUT_CYCLES, 16, entry inactivity limit in clk_1 cycles (used only with PW_CHG_TIMEOUT_EN)

Ports:
clk_1  input  1  slow system clock (divided from clk_50)
rst  input  1  reset, asynchronous, active-high
chg_req  input  1  user requests a password change (level)
auth  input  1  lock reports a successful verify; change allowed only while high
USERIN  input  4  hex digit from switches
KEY  input  4  active-low confirm buttons; KEY[3-i] confirms digit i
pw_out  output  16  stored password, digit0 in [15:12]
pw_upd  output  1  one-cycle pulse when pw_out is updated
busy  output  1  high in any state other than IDLE
LEDG  output  1  change succeeded
LEDR  output  1  change failed
H0..H3  output  7 each  7-seg digits 0..3, active-low

Behaviour:
- Clocking: all state changes on posedge clk_1. rst is asynchronous, active-high. KEY/USERIN are sampled as levels at the clock edge.
- Reset values: state=IDLE, pw_out=DEFAULT_PW, newpw=confpw=0, pw_upd=0, busy=0, LEDG=LEDR=0, H0..H3=7'b0111111 (dash), cnt=0, blink=0.
- States (4-bit encoding): IDLE, NEW0..NEW3, CONF0..CONF3, CHECK, DONE, ERR.
- IDLE:
  - H*=dash, LEDG=LEDR=0.
  - chg_req&&auth -> NEW0, with blink=0 and newpw=confpw=0.
  - chg_req&&!auth -> stay in IDLE.
- NEWi (i=0..3):
  - Hi shows blink ? 7'b1111111 : hex(USERIN); blink toggles every cycle in entry states.
  - KEY[3-i]==0 -> Hi=hex(USERIN), newpw[15-4i -:4]=USERIN, next state. Other KEY bits are ignored.
  - NEW3 exits to CONF0, setting H0..H3=dash.
- CONFi: same as NEWi but writes confpw. CONF3 exits to CHECK.
- Cancel: chg_req==0 in any NEW/CONF state -> IDLE next edge, no commit. Cancel has priority over a simultaneous key press.
- CHECK (1 cycle):
  - newpw==confpw -> DONE, with pw_out<=newpw and pw_upd=1 on that same edge.
  - Otherwise -> ERR, pw_out unchanged.
  - cnt=0 in both cases.
- pw_upd: high for exactly the one cycle following the commit edge.
- DONE:
  - LEDG=1; H0..H3 = d,o,n,E = 0100001, 0100011, 0101011, 0000110.
  - cnt increments each cycle; cnt==HOLD_CYCLES-1 -> IDLE, cnt=0.
- ERR:
  - LEDR=1; H0..H3 = E,r,r,dash = 0000110, 0101111, 0101111, 0111111.
  - Same hold rule as DONE.
- chg_req/auth are ignored in DONE and ERR.
- hex(): full 0-F glyph set, active-low, e.g. 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, A=0001000, F=0001110.
- Reset at any point, including mid-entry: immediate return to reset values; pw_out reverts to DEFAULT_PW (no non-volatile storage).
- cnt is wide enough for max(HOLD_CYCLES, TIMEOUT_CYCLES).

Optional Feature:
- Macro PW_CHG_TIMEOUT_EN.
- Defined: an inactivity counter clears on entering NEW0 and on every digit confirm, and increments each cycle in NEW/CONF states. Reaching TIMEOUT_CYCLES -> ERR (cnt=0), no commit. Cancel takes precedence over timeout.
- Undefined: no counter; entry states wait indefinitely.

Test Plan:
1. Assert rst -> pw_out=16'h01AF, H0..H3=7'b0111111, LEDG=LEDR=0, busy=0, pw_upd=0.
2. auth=1, chg_req=1; enter 1,2,3,4 via KEY[3..0], then 1,2,3,4 again -> CHECK then DONE; pw_out=16'h1234; pw_upd high 1 cycle; LEDG=1 and H=donE for 7 cycles; then IDLE with LEDG=0.
3. Enter 1,2,3,4 then confirm 1,2,3,5 -> ERR; LEDR=1; H=Err-; pw_out stays 16'h01AF; pw_upd never asserted; IDLE after 7 cycles.
4. chg_req=1, auth=0 for 20 cycles -> remains IDLE, busy=0. Drop chg_req in NEW2 while KEY[1]=0 -> IDLE, newpw not committed.
5. Commit 16'h1234, then assert rst during CONF2 of a second change -> immediate reset values, pw_out=16'h01AF.
6. (PW_CHG_TIMEOUT_EN) enter digit 0, then no keys for 16 cycles in NEW1 -> ERR, LEDR=1, pw_out unchanged. Without the macro the same stimulus stays in NEW1.
